arcade_input_ctrl: RTL and testbench
====================================

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 Parameter PLAYERS, default 2: player channels; legal range 1..4.
REQ-002 Parameter COIN_HOLD, default 16'd50000: cycles a coin pulse is held asserted; legal range 1..65535.
REQ-003 Parameter AUTOFIRE_DIV, default 16'd6000: autofire half-period in cycles; legal range 1..65535.
REQ-004 clk_sys  in  1  system clock; one clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ps2_key  in  11  [10] toggle per key event, [9] pressed, [8:0] scan code (E0-extended code in bit 8).
REQ-007 joystick  in  16*PLAYERS  per-player pad word; bit 4 fire, bit 5 start, bit 6 coin.
REQ-008 autofire_en  in  PLAYERS  per-player autofire enable.
REQ-009 coin_on_start  in  1  when 1, a start request also raises a coin request for the same player.
REQ-010 fire_n, start_n, coin_n  out  PLAYERS each  active-low controls to the game core.

Function
REQ-011 Key event: detected when ps2_key[10] differs from its value registered on the previous cycle; one event per toggle.
REQ-012 On an event, the matching key latch takes ps2_key[9]; non-matching codes and players >= PLAYERS are ignored.
REQ-013 Key map, fire: P0 0x029 and 0x014 (shared latch), P1 0x01C, P2 0x015, P3 0x01D.
REQ-014 Key map, start: P0 0x016 and 0x005, P1 0x01E and 0x006, P2 0x026, P3 0x025.
REQ-015 Key map, coin: P0 0x02E, P1 0x036, P2 0x03D, P3 0x03E.
REQ-016 Raw request per player = key latch OR joystick bit; start_req additionally ORs nothing else.
REQ-017 start_n[p] = ~start_req[p], registered; latency 1 cycle from latch or joystick change.
REQ-018 coin_req[p] = coin key OR joystick coin bit OR (coin_on_start AND start_req[p]).
REQ-019 Coin FSM per player, states IDLE, HOLD, WAIT_REL; reset state IDLE.
REQ-020 IDLE -> HOLD on coin_req high; load 16-bit counter with COIN_HOLD-1; coin_n low from the next cycle.
REQ-021 HOLD: counter decrements each cycle; at 0 -> WAIT_REL with coin_n high; pulse width exactly COIN_HOLD cycles.
REQ-022 Requests during HOLD are ignored; there is no retrigger or extension.
REQ-023 WAIT_REL -> IDLE when coin_req low; a held request yields exactly one pulse.
REQ-024 Fire with autofire_en[p]=0: fire_n[p] = ~fire_req[p], registered, latency 1.
REQ-025 Fire with autofire_en[p]=1, on fire_req rise: fire_n low next cycle and per-player phase counter cleared.
REQ-026 Autofire while fire_req held: phase toggles every AUTOFIRE_DIV cycles; fire_n low in even phases; release -> fire_n high next cycle.
REQ-027 autofire_en change mid-hold: takes effect next cycle; enabling restarts at phase 0 (asserted).
REQ-028 Simultaneous key events for one player in one cycle cannot occur (one ps2_key word); keyboard and joystick for the same control are ORed, never prioritised.
REQ-029 Channels are independent; counters saturate neither up nor down beyond the rules above.

Reset
REQ-030 While reset high: all key latches 0, coin FSMs IDLE, counters 0, prev toggle <= ps2_key[10] (no spurious event on release).
REQ-031 All outputs are 1 (inactive) on the first cycle after reset asserts and while held.
REQ-032 Reset mid-HOLD aborts the pulse; coin_n high next cycle; a still-held request after reset gives a new full pulse.

Verification
REQ-033 PLAYERS=2, COIN_HOLD=4: toggle ps2_key to {1,1,0x02E} -> coin_n[0] low exactly 4 cycles starting 2 cycles after toggle edge, then high while key held.
REQ-034 coin_on_start=1, joystick[5] held 20 cycles, COIN_HOLD=4 -> start_n[0] low 20 cycles, exactly one 4-cycle coin_n[0] pulse.
REQ-035 AUTOFIRE_DIV=3, autofire_en[1]=1, joystick[20] held 12 cycles -> fire_n[1] pattern 0,0,0,1,1,1,0,0,0,1,1,1 then 1 after release.
REQ-036 Key 0x01C pressed and joystick[20] pulsed with autofire_en=0 -> fire_n[1] low until keyboard release event, unaffected by pad release.
REQ-037 Reset asserted at cycle 2 of a COIN_HOLD=10 pulse -> coin_n high next cycle; request held after reset -> fresh 10-cycle pulse.
REQ-038 PLAYERS=1, code 0x036 pressed -> no output change; ps2_key toggle during reset -> no event after reset release.

Source files
------------

// File: rtl/arcade_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_ctrl_if
// Description : Host-side inputs and active-low game-core controls for the
//               arcade input controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface arcade_input_ctrl_if #(
    parameter int PLAYERS = 2
);
    logic [10:0]            ps2_key;
    logic [16*PLAYERS-1:0]  joystick;
    logic [PLAYERS-1:0]     autofire_en;
    logic                   coin_on_start;
    logic [PLAYERS-1:0]     fire_n;
    logic [PLAYERS-1:0]     start_n;
    logic [PLAYERS-1:0]     coin_n;

    modport master (
        output ps2_key,
        output joystick,
        output autofire_en,
        output coin_on_start,
        input  fire_n,
        input  start_n,
        input  coin_n
    );

    modport slave (
        input  ps2_key,
        input  joystick,
        input  autofire_en,
        input  coin_on_start,
        output fire_n,
        output start_n,
        output coin_n
    );
endinterface
`default_nettype wire

// File: rtl/arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_ctrl
// Description : Merges PS/2 keys and pads into per-player fire/start/coin,
//               with fixed-width coin pulses and optional autofire.
// Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_ctrl #(
    parameter int          PLAYERS      = 2,
    parameter logic [15:0] COIN_HOLD    = 16'd50000,
    parameter logic [15:0] AUTOFIRE_DIV = 16'd6000
) (
    input  wire logic          clk_sys,
    input  wire logic          reset,
    arcade_input_ctrl_if.slave ctrl
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_HOLD     = 2'd1;
    localparam logic [1:0]  S_WAIT_REL = 2'd2;

    localparam logic [15:0] c_coin_load = COIN_HOLD - 16'd1;
    localparam logic [15:0] c_af_last   = AUTOFIRE_DIV - 16'd1;

    // ------------------------------------------------------------------------
    // Key map
    // ------------------------------------------------------------------------
    function automatic logic f_is_fire(input logic [8:0] code, input int p);
        case (p)
            0:       return (code == 9'h029) || (code == 9'h014);
            1:       return (code == 9'h01C);
            2:       return (code == 9'h015);
            3:       return (code == 9'h01D);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f_is_start(input logic [8:0] code, input int p);
        case (p)
            0:       return (code == 9'h016) || (code == 9'h005);
            1:       return (code == 9'h01E) || (code == 9'h006);
            2:       return (code == 9'h026);
            3:       return (code == 9'h025);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic f_is_coin(input logic [8:0] code, input int p);
        case (p)
            0:       return (code == 9'h02E);
            1:       return (code == 9'h036);
            2:       return (code == 9'h03D);
            3:       return (code == 9'h03E);
            default: return 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Key event detection
    // ------------------------------------------------------------------------
    logic       r_ps2_tog;
    logic       w_key_event;
    logic       w_key_pressed;
    logic [8:0] w_key_code;

    // Tracked through reset too, so a toggle seen during reset is never
    // replayed as an event once reset drops.
    always_ff @(posedge clk_sys) begin
        r_ps2_tog <= ctrl.ps2_key[10];
    end

    assign w_key_event   = ctrl.ps2_key[10] ^ r_ps2_tog;
    assign w_key_pressed = ctrl.ps2_key[9];
    assign w_key_code    = ctrl.ps2_key[8:0];

    wire [PLAYERS-1:0] w_fire_n;
    wire [PLAYERS-1:0] w_start_n;
    wire [PLAYERS-1:0] w_coin_n;

    // ------------------------------------------------------------------------
    // Per-player channels
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic        r_fire_key;
        logic        r_start_key;
        logic        r_coin_key;
        logic        w_fire_req;
        logic        w_start_req;
        logic        w_coin_req;
        logic        w_unused_joy;

        logic        r_start_n;

        logic [1:0]  r_coin_state;
        logic [1:0]  w_coin_state_nxt;
        logic [15:0] r_coin_cnt;
        logic [15:0] w_coin_cnt_nxt;
        logic        r_coin_n;

        logic        w_af_en;
        logic        r_af_en_d;
        logic        r_fire_req_d;
        logic        w_af_restart;
        logic        r_af_phase;
        logic        w_af_phase_nxt;
        logic [15:0] r_af_cnt;
        logic [15:0] w_af_cnt_nxt;
        logic        r_fire_n;

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_fire_key  <= 1'b0;
                r_start_key <= 1'b0;
                r_coin_key  <= 1'b0;
            end else if (w_key_event) begin
                if (f_is_fire(w_key_code, p))  r_fire_key  <= w_key_pressed;
                if (f_is_start(w_key_code, p)) r_start_key <= w_key_pressed;
                if (f_is_coin(w_key_code, p))  r_coin_key  <= w_key_pressed;
            end
        end

        assign w_fire_req   = r_fire_key  | ctrl.joystick[16*p+4];
        assign w_start_req  = r_start_key | ctrl.joystick[16*p+5];
        assign w_coin_req   = r_coin_key  | ctrl.joystick[16*p+6]
                            | (ctrl.coin_on_start & w_start_req);
        assign w_unused_joy = ^{ctrl.joystick[16*p+15 : 16*p+7],
                                ctrl.joystick[16*p+3  : 16*p]};

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_start_n <= 1'b1;
            end else begin
                r_start_n <= ~w_start_req;
            end
        end

        // Coin pulse: exactly COIN_HOLD cycles, then wait for release so a
        // held request never produces a second pulse.
        always_comb begin
            w_coin_state_nxt = r_coin_state;
            w_coin_cnt_nxt   = r_coin_cnt;
            case (r_coin_state)
                S_IDLE: begin
                    if (w_coin_req) begin
                        w_coin_state_nxt = S_HOLD;
                        w_coin_cnt_nxt   = c_coin_load;
                    end
                end
                S_HOLD: begin
                    if (r_coin_cnt == 16'd0) begin
                        w_coin_state_nxt = S_WAIT_REL;
                    end else begin
                        w_coin_cnt_nxt = r_coin_cnt - 16'd1;
                    end
                end
                S_WAIT_REL: begin
                    if (!w_coin_req) begin
                        w_coin_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_coin_state_nxt = S_IDLE;
                    w_coin_cnt_nxt   = 16'd0;
                end
            endcase
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_coin_state <= S_IDLE;
                r_coin_cnt   <= 16'd0;
                r_coin_n     <= 1'b1;
            end else begin
                r_coin_state <= w_coin_state_nxt;
                r_coin_cnt   <= w_coin_cnt_nxt;
                r_coin_n     <= (w_coin_state_nxt != S_HOLD);
            end
        end

        // Autofire restarts in the asserted phase on a new press and when
        // autofire is switched on while the button is already held.
        assign w_af_en      = ctrl.autofire_en[p];
        assign w_af_restart = w_fire_req & (~r_fire_req_d | (w_af_en & ~r_af_en_d));

        always_comb begin
            w_af_cnt_nxt   = r_af_cnt;
            w_af_phase_nxt = r_af_phase;
            if (!w_fire_req || w_af_restart) begin
                w_af_cnt_nxt   = 16'd0;
                w_af_phase_nxt = 1'b0;
            end else if (r_af_cnt == c_af_last) begin
                w_af_cnt_nxt   = 16'd0;
                w_af_phase_nxt = ~r_af_phase;
            end else begin
                w_af_cnt_nxt = r_af_cnt + 16'd1;
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_fire_req_d <= 1'b0;
                r_af_en_d    <= 1'b0;
                r_af_cnt     <= 16'd0;
                r_af_phase   <= 1'b0;
                r_fire_n     <= 1'b1;
            end else begin
                r_fire_req_d <= w_fire_req;
                r_af_en_d    <= w_af_en;
                r_af_cnt     <= w_af_cnt_nxt;
                r_af_phase   <= w_af_phase_nxt;
                if (w_af_en) begin
                    r_fire_n <= ~(w_fire_req & ~w_af_phase_nxt);
                end else begin
                    r_fire_n <= ~w_fire_req;
                end
            end
        end

        assign w_fire_n[p]  = r_fire_n;
        assign w_start_n[p] = r_start_n;
        assign w_coin_n[p]  = r_coin_n;
    end

    assign ctrl.fire_n  = w_fire_n;
    assign ctrl.start_n = w_start_n;
    assign ctrl.coin_n  = w_coin_n;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arcade_input_ctrl
// Description : Directed vectors and corner-case sequences for two
//               configurations of arcade_input_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_ctrl;

    logic clk_sys = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if #(.PLAYERS(2)) if_a ();
    arcade_input_ctrl_if #(.PLAYERS(1)) if_b ();

    arcade_input_ctrl #(
        .PLAYERS      (2),
        .COIN_HOLD    (16'd4),
        .AUTOFIRE_DIV (16'd3)
    ) u_dut_a (
        .clk_sys (clk_sys),
        .reset   (rst_a),
        .ctrl    (if_a)
    );

    arcade_input_ctrl #(
        .PLAYERS      (1),
        .COIN_HOLD    (16'd10),
        .AUTOFIRE_DIV (16'd3)
    ) u_dut_b (
        .clk_sys (clk_sys),
        .reset   (rst_b),
        .ctrl    (if_b)
    );

    typedef struct {
        logic        do_key;
        logic        pressed;
        logic [8:0]  code;
        logic [31:0] joy;
        logic [1:0]  exp_fire_n;
        logic [1:0]  exp_start_n;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int n_checks;
    int n_errors;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic key_a(input logic pressed, input logic [8:0] code);
        if_a.ps2_key = {~if_a.ps2_key[10], pressed, code};
    endtask

    task automatic key_b(input logic pressed, input logic [8:0] code);
        if_b.ps2_key = {~if_b.ps2_key[10], pressed, code};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [9:0]  pat33;
        logic [12:0] pat35;
        logic [15:0] pat37;
        int          lows_start;
        int          lows_coin;
        int          pulses;
        logic        prev;

        n_checks = 0;
        n_errors = 0;

        //            key   prs   code     joy            fire_n  start_n
        vecs[0]  = '{1'b1, 1'b1, 9'h029, 32'h0000_0000, 2'b10, 2'b11};
        vecs[1]  = '{1'b1, 1'b1, 9'h016, 32'h0000_0000, 2'b10, 2'b10};
        vecs[2]  = '{1'b1, 1'b0, 9'h029, 32'h0000_0000, 2'b11, 2'b10};
        vecs[3]  = '{1'b1, 1'b1, 9'h014, 32'h0000_0000, 2'b10, 2'b10};
        vecs[4]  = '{1'b1, 1'b0, 9'h029, 32'h0000_0000, 2'b11, 2'b10};
        vecs[5]  = '{1'b1, 1'b0, 9'h016, 32'h0000_0000, 2'b11, 2'b11};
        vecs[6]  = '{1'b0, 1'b0, 9'h000, 32'h0020_0000, 2'b11, 2'b01};
        vecs[7]  = '{1'b1, 1'b1, 9'h006, 32'h0020_0000, 2'b11, 2'b01};
        vecs[8]  = '{1'b0, 1'b0, 9'h000, 32'h0000_0000, 2'b11, 2'b01};
        vecs[9]  = '{1'b1, 1'b0, 9'h01E, 32'h0000_0000, 2'b11, 2'b11};
        vecs[10] = '{1'b1, 1'b1, 9'h11C, 32'h0000_0000, 2'b11, 2'b11};
        vecs[11] = '{1'b1, 1'b1, 9'h015, 32'h0000_0000, 2'b11, 2'b11};
        vecs[12] = '{1'b1, 1'b1, 9'h01C, 32'h0000_0000, 2'b01, 2'b11};
        vecs[13] = '{1'b0, 1'b0, 9'h000, 32'h0000_0010, 2'b00, 2'b11};
        vecs[14] = '{1'b0, 1'b0, 9'h000, 32'h0000_0000, 2'b01, 2'b11};
        vecs[15] = '{1'b1, 1'b0, 9'h01C, 32'h0000_0000, 2'b11, 2'b11};
        vecs[16] = '{1'b1, 1'b1, 9'h005, 32'h0000_0000, 2'b11, 2'b10};
        vecs[17] = '{1'b1, 1'b0, 9'h005, 32'h0000_0000, 2'b11, 2'b11};

        // Reset with every P0 request active: outputs must stay inactive.
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.ps2_key       = '0;
        if_a.joystick      = 32'h0000_0070;
        if_a.autofire_en   = 2'b00;
        if_a.coin_on_start = 1'b1;
        if_b.ps2_key       = '0;
        if_b.joystick      = 16'h0070;
        if_b.autofire_en   = 1'b0;
        if_b.coin_on_start = 1'b0;
        tick();
        check("reset_a_first", {26'd0, if_a.fire_n, if_a.start_n, if_a.coin_n}, 32'h3F);
        tick();
        tick();
        check("reset_a_held", {26'd0, if_a.fire_n, if_a.start_n, if_a.coin_n}, 32'h3F);
        check("reset_b_held", {29'd0, if_b.fire_n, if_b.start_n, if_b.coin_n}, 32'h7);
        if_a.joystick      = '0;
        if_a.coin_on_start = 1'b0;
        if_b.joystick      = '0;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        tick();

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].do_key) key_a(vecs[i].pressed, vecs[i].code);
            if_a.joystick = vecs[i].joy;
            tick();
            tick();
            check($sformatf("vec%0d_fire_n", i), {30'd0, if_a.fire_n}, {30'd0, vecs[i].exp_fire_n});
            check($sformatf("vec%0d_start_n", i), {30'd0, if_a.start_n}, {30'd0, vecs[i].exp_start_n});
        end
        check("table_coin_idle", {30'd0, if_a.coin_n}, 32'h3);

        // Coin key held: one 4-cycle pulse beginning two edges after the toggle.
        pat33 = 10'b1000011111;
        key_a(1'b1, 9'h02E);
        for (int s = 1; s <= 10; s++) begin
            tick();
            check($sformatf("coin_key_s%0d", s), {31'd0, if_a.coin_n[0]}, {31'd0, pat33[10-s]});
        end
        check("coin_key_p1_idle", {31'd0, if_a.coin_n[1]}, 32'd1);
        key_a(1'b0, 9'h02E);
        tick();
        tick();
        tick();
        check("coin_after_release", {31'd0, if_a.coin_n[0]}, 32'd1);

        // Start with coin_on_start: 20 cycles of start, a single coin pulse.
        if_a.coin_on_start = 1'b1;
        if_a.joystick      = 32'h0000_0020;
        lows_start = 0;
        lows_coin  = 0;
        pulses     = 0;
        prev       = 1'b1;
        for (int s = 1; s <= 26; s++) begin
            tick();
            if (!if_a.start_n[0]) lows_start++;
            if (!if_a.coin_n[0]) lows_coin++;
            if (prev && !if_a.coin_n[0]) pulses++;
            prev = if_a.coin_n[0];
            if (s == 20) if_a.joystick = '0;
        end
        check("cos_start_low_cycles", lows_start, 32'd20);
        check("cos_coin_low_cycles", lows_coin, 32'd4);
        check("cos_coin_pulses", pulses, 32'd1);
        if_a.coin_on_start = 1'b0;
        tick();
        tick();

        // Autofire on P1, DIV=3, held 12 cycles then released.
        pat35 = 13'b0001110001111;
        if_a.autofire_en = 2'b10;
        if_a.joystick    = 32'h0010_0000;
        for (int s = 1; s <= 13; s++) begin
            tick();
            check($sformatf("af_s%0d", s), {31'd0, if_a.fire_n[1]}, {31'd0, pat35[13-s]});
            if (s == 12) if_a.joystick = '0;
        end

        // Autofire switched on mid-hold restarts in the asserted phase.
        if_a.autofire_en = 2'b00;
        if_a.joystick    = 32'h0010_0000;
        tick();
        tick();
        check("af_off_hold", {31'd0, if_a.fire_n[1]}, 32'd0);
        if_a.autofire_en = 2'b10;
        for (int s = 1; s <= 4; s++) begin
            tick();
            check($sformatf("af_enable_s%0d", s), {31'd0, if_a.fire_n[1]}, (s == 4) ? 32'd1 : 32'd0);
        end
        if_a.autofire_en = 2'b00;
        tick();
        check("af_disable_hold", {31'd0, if_a.fire_n[1]}, 32'd0);
        if_a.joystick = '0;
        tick();
        check("af_disable_release", {31'd0, if_a.fire_n[1]}, 32'd1);

        // Keyboard fire held while the pad pulses: only the key release ends it.
        key_a(1'b1, 9'h01C);
        if_a.joystick = 32'h0010_0000;
        tick();
        if_a.joystick = '0;
        tick();
        tick();
        check("kbd_pad_release", {31'd0, if_a.fire_n[1]}, 32'd0);
        tick();
        tick();
        check("kbd_still_held", {31'd0, if_a.fire_n[1]}, 32'd0);
        key_a(1'b0, 9'h01C);
        tick();
        check("kbd_release_lat0", {31'd0, if_a.fire_n[1]}, 32'd0);
        tick();
        check("kbd_release_lat1", {31'd0, if_a.fire_n[1]}, 32'd1);

        // Reset two cycles into a 10-cycle pulse, request still held.
        pat37 = 16'b0010000000000111;
        if_b.joystick = 16'h0040;
        for (int s = 1; s <= 16; s++) begin
            tick();
            check($sformatf("rst_mid_s%0d", s), {31'd0, if_b.coin_n[0]}, {31'd0, pat37[16-s]});
            if (s == 2) rst_b = 1'b1;
            if (s == 3) rst_b = 1'b0;
        end
        if_b.joystick = '0;
        tick();
        tick();

        // Single-player build ignores the P1 coin key.
        key_b(1'b1, 9'h036);
        lows_coin = 0;
        for (int s = 1; s <= 6; s++) begin
            tick();
            if ({if_b.fire_n, if_b.start_n, if_b.coin_n} != 3'b111) lows_coin++;
        end
        check("p1_key_ignored", lows_coin, 32'd0);

        // A toggle during reset must not surface as an event afterwards.
        rst_b = 1'b1;
        tick();
        key_b(1'b1, 9'h02E);
        tick();
        tick();
        rst_b = 1'b0;
        lows_coin = 0;
        for (int s = 1; s <= 8; s++) begin
            tick();
            if (!if_b.coin_n[0]) lows_coin++;
        end
        check("no_event_after_reset", lows_coin, 32'd0);

        key_b(1'b1, 9'h02E);
        lows_coin = 0;
        for (int s = 1; s <= 14; s++) begin
            tick();
            if (!if_b.coin_n[0]) lows_coin++;
        end
        check("b_coin_pulse_width", lows_coin, 32'd10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
